multicycle_control_unit: RTL
============================

# multicycle_control_unit

Multi-cycle instruction sequencer that replaces the single-cycle opcode decoder in the CPU datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath strobes one state at a time. It waits on a memory-ready handshake, aborts stalled memory accesses after a programmable timeout, and counts retired instructions. It sits between the instruction register and the datapath/memory interface.

## Interface

Parameters:
- OPCODE_W, 7, opcode width.
- REGDST_W, 3, width of regDst select.
- RD_SEL, 3'b000, regDst code for R-type writeback (rd).
- RT_SEL, 3'b001, regDst code for LW writeback (rt).
- MEM_TIMEOUT, 16, consecutive not-ready cycles before abort; 0 disables the timeout.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- opcode  in  OPCODE_W  opcode field from the instruction register; sampled only in DECODE.
- memReady  in  1  memory handshake; current access completes on a cycle where it is 1.
- pcWrite  out  1  PC update strobe.
- irWrite  out  1  instruction register load strobe.
- iorD  out  1  memory address select: 0 = PC, 1 = ALU result.
- memRead  out  1  memory read request.
- memWrite  out  1  memory write request.
- aluOp  out  2  00 = add (address), 01 = subtract (branch compare), 10 = R-type funct.
- branch  out  1  conditional PC update enable.
- regWrite  out  1  register file write strobe.
- regDst  out  REGDST_W  register file write-select code.
- instrDone  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- busErr  out  1  one-cycle pulse on a memory timeout.
- retired  out  CNT_W  count of retired instructions; wraps to 0 after all-ones.

## Operation

- Opcodes: R = 7'b0000000, LW = 7'b0001000, SW = 7'b0010000, BEQ = 7'b0011000. All other values are illegal.
- Outputs are Moore outputs, decoded from state and the latched opcode register opReg. Any output not listed for a state is 0.
- IDLE (entered by reset): all outputs 0. Next state is FETCH unconditionally.
- FETCH: memRead = 1, iorD = 0.
  - If memReady = 1: irWrite = 1 and pcWrite = 1 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: opReg <= opcode.
  - R goes to EXEC.
  - LW and SW go to ADDR.
  - BEQ goes to BRANCH.
  - An illegal opcode raises illegal = 1 this cycle and goes to FETCH; retired is not incremented.
- EXEC: aluOp = 10, then WB.
- ADDR: aluOp = 00, then MEM.
- MEM: iorD = 1.
  - LW: memRead = 1. Go to WB when memReady = 1.
  - SW: memWrite = 1. When memReady = 1, pulse instrDone and go to FETCH.
- WB: regWrite = 1 and instrDone = 1. regDst = RD_SEL for R, RT_SEL for LW. Then go to FETCH.
- BRANCH: aluOp = 01, branch = 1, instrDone = 1, then go to FETCH.
- retired increments by 1 on every cycle where instrDone = 1. It wraps modulo 2^CNT_W.
- Timeout counter:
  - Clears on entry to FETCH or MEM.
  - Increments on each cycle in FETCH or MEM with memReady = 0.
  - When it reaches MEM_TIMEOUT with memReady still 0: busErr = 1 that cycle and the next state is FETCH. The aborted instruction is not retired and the counter clears.
  - If memReady = 1 on the timeout cycle, completion wins and busErr stays 0.
  - MEM_TIMEOUT = 0 disables the timeout: the block waits indefinitely.
- When rst is asserted, mid-instruction or otherwise: state goes to IDLE, opReg and retired go to 0, the timeout counter clears, and all outputs are 0 immediately (asynchronously).

## Timing

- Latencies with memReady held at 1:
  - R: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - Illegal: 2 cycles.
- Each cycle memReady is 0 in FETCH or MEM adds 1 cycle.
- After rst deasserts, the first FETCH cycle is the second rising edge.
- instrDone, illegal and busErr are each exactly one cycle wide and never overlap.
- The opcode input is ignored outside DECODE.

## Test plan

- Reset mid-MEM of an SW: assert rst asynchronously -> memWrite drops to 0 without waiting for a clock edge and retired = 0. Release rst -> IDLE, then memRead = 1 one cycle later.
- R-type with memReady = 1: instrDone on cycle 4, regWrite = 1 with regDst = 3'b000, retired = 1. A following LW gives regDst = 3'b001, instrDone 5 cycles later, retired = 2.
- SW with memReady low for 3 cycles in MEM: memWrite = 1 for 4 cycles, instrDone on the 4th MEM cycle, regWrite never asserted.
- Opcode 7'b1111111: illegal pulses in DECODE, FETCH follows, retired unchanged. BEQ: branch = 1 and aluOp = 01 on cycle 3.
- MEM_TIMEOUT = 4, memReady held 0 in FETCH: busErr on the 4th FETCH cycle, then re-enter FETCH with the counter cleared. Repeat with memReady = 1 on the 4th cycle -> no busErr, DECODE follows.
- CNT_W = 4: retire 16 BEQs -> retired wraps 15 -> 0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory bundle: opcode and memory handshake in,
// per-state datapath strobes, event pulses and the retired count out.
interface multicycle_control_unit_if #(
   parameter int OPCODE_W = 7,
   parameter int REGDST_W = 3,
   parameter int CNT_W    = 16
);
   logic [OPCODE_W-1:0] opcode;
   logic                memReady;
   logic                pcWrite;
   logic                irWrite;
   logic                iorD;
   logic                memRead;
   logic                memWrite;
   logic [1:0]          aluOp;
   logic                branch;
   logic                regWrite;
   logic [REGDST_W-1:0] regDst;
   logic                instrDone;
   logic                illegal;
   logic                busErr;
   logic [CNT_W-1:0]    retired;

   modport master (
      input  opcode, memReady,
      output pcWrite, irWrite, iorD, memRead, memWrite, aluOp, branch,
             regWrite, regDst, instrDone, illegal, busErr, retired
   );

   modport slave (
      output opcode, memReady,
      input  pcWrite, irWrite, iorD, memRead, memWrite, aluOp, branch,
             regWrite, regDst, instrDone, illegal, busErr, retired
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer: one datapath state per cycle (R 4, LW 5, SW 4, BEQ 3);
// FETCH/MEM stall on memReady and abort with busErr after MEM_TIMEOUT idle cycles.
module multicycle_control_unit #(
   parameter int                  OPCODE_W    = 7,
   parameter int                  REGDST_W    = 3,
   parameter logic [REGDST_W-1:0] RD_SEL      = 3'b000,
   parameter logic [REGDST_W-1:0] RT_SEL      = 3'b001,
   parameter int                  MEM_TIMEOUT = 16,
   parameter int                  CNT_W       = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   multicycle_control_unit_if.master  bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ADDR, S_MEM, S_WB, S_BRANCH
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(7'b0000000);
   localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(7'b0001000);
   localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(7'b0010000);
   localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(7'b0011000);

   // Counter only needs to reach MEM_TIMEOUT-1; the abort fires on that cycle.
   localparam int TMO_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam int TMO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

   state_t              state_q, state_d;
   logic [OPCODE_W-1:0] op_q, op_d;
   logic [CNT_W-1:0]    retired_q, retired_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                tmo_hit;
   logic                abort;
   logic                done;

   assign tmo_hit = (MEM_TIMEOUT != 0) && !bus.memReady &&
                    (tmo_q == TMO_W'(TMO_LAST));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         retired_q <= '0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         retired_q <= retired_d;
         tmo_q     <= tmo_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      tmo_d         = '0;
      abort         = 1'b0;
      done          = 1'b0;
      bus.pcWrite   = 1'b0;
      bus.irWrite   = 1'b0;
      bus.iorD      = 1'b0;
      bus.memRead   = 1'b0;
      bus.memWrite  = 1'b0;
      bus.aluOp     = 2'b00;
      bus.branch    = 1'b0;
      bus.regWrite  = 1'b0;
      bus.regDst    = '0;
      bus.illegal   = 1'b0;
      bus.busErr    = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            bus.memRead = 1'b1;
            if (bus.memReady) begin
               bus.irWrite = 1'b1;
               bus.pcWrite = 1'b1;
               state_d     = S_DECODE;
            end else if (tmo_hit) begin
               bus.busErr = 1'b1;
               abort      = 1'b1;
            end
         end
         S_DECODE: begin
            op_d = bus.opcode;
            case (bus.opcode)
               OP_R:         state_d = S_EXEC;
               OP_LW, OP_SW: state_d = S_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               default: begin
                  bus.illegal = 1'b1;
                  state_d     = S_FETCH;
               end
            endcase
         end
         S_EXEC: begin
            bus.aluOp = 2'b10;
            state_d   = S_WB;
         end
         S_ADDR:  state_d = S_MEM;
         S_MEM: begin
            bus.iorD = 1'b1;
            if (op_q == OP_LW) bus.memRead  = 1'b1;
            else               bus.memWrite = 1'b1;
            if (bus.memReady) begin
               if (op_q == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  done    = 1'b1;
                  state_d = S_FETCH;
               end
            end else if (tmo_hit) begin
               bus.busErr = 1'b1;
               abort      = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_WB: begin
            bus.regWrite = 1'b1;
            bus.regDst   = (op_q == OP_LW) ? RT_SEL : RD_SEL;
            done         = 1'b1;
            state_d      = S_FETCH;
         end
         S_BRANCH: begin
            bus.aluOp  = 2'b01;
            bus.branch = 1'b1;
            done       = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase

      // Stalling in place counts up; any entry or abort restarts from zero.
      if (!abort && (state_d == state_q) &&
          (state_q == S_FETCH || state_q == S_MEM))
         tmo_d = tmo_q + TMO_W'(1);

      retired_d     = done ? retired_q + CNT_W'(1) : retired_q;
      bus.instrDone = done;
   end

   assign bus.retired = retired_q;
endmodule
